// File: rtl/cpu_fetch_sequencer.sv
// Fetch/execute sequencer: owns PC, IR and the EX0/EX1 State bit, fetches over
// an IMEM req/valid handshake and applies the decoder's PS/IR_L/NS each EXEC cycle.
module cpu_fetch_sequencer #(
  parameter int                PC_W         = 16,
  parameter logic [PC_W-1:0]   RESET_VECTOR = '0
) (
  input  logic            CLK,
  input  logic            RST_n,
  input  logic [1:0]      PS,
  input  logic            IR_L,
  input  logic            NS,
  input  logic [15:0]     RA_Data,
  input  logic [15:0]     Offset,
  input  logic            Stall,
  input  logic            IMEM_Valid,
  input  logic [15:0]     IMEM_Data,
  output logic            IMEM_Req,
  output logic [PC_W-1:0] IMEM_Addr,
  output logic [15:0]     IR,
  output logic            State,
  output logic [PC_W-1:0] PC,
  output logic            Exec,
  output logic [15:0]     InstCount
);

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } fsm_t;

  fsm_t            fsm_q, fsm_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic            state_q, state_d;
  logic            req_q, req_d;
  logic [15:0]     count_q, count_d;

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      fsm_q   <= FETCH;
      pc_q    <= RESET_VECTOR;
      ir_q    <= '0;
      state_q <= 1'b0;
      req_q   <= 1'b0;
      count_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      state_q <= state_d;
      req_q   <= req_d;
      count_q <= count_d;
    end
  end

  // Request is raised one edge after entering FETCH, so a stray IMEM_Valid
  // before that edge can never be taken as the answer.
  always_comb begin
    fsm_d   = fsm_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    state_d = state_q;
    req_d   = req_q;
    count_d = count_q;
    case (fsm_q)
      FETCH: begin
        if (!req_q) begin
          req_d = 1'b1;
        end else if (IMEM_Valid) begin
          ir_d    = IMEM_Data;
          state_d = 1'b0;
          req_d   = 1'b0;
          fsm_d   = EXEC;
        end
      end
      EXEC: begin
        if (!Stall) begin
          case (PS)
            2'b00:   pc_d = pc_q;
            2'b01:   pc_d = pc_q + PC_W'(1);
            2'b10:   pc_d = RA_Data[PC_W-1:0];
            default: pc_d = pc_q + Offset[PC_W-1:0];
          endcase
          state_d = NS;
          // NS=1 keeps us in EXEC for EX1 even if the decoder also flags completion.
          if (!NS && IR_L) begin
            fsm_d   = FETCH;
            count_d = count_q + 16'd1;
          end
        end
      end
      default: fsm_d = FETCH;
    endcase
  end

  assign Exec      = (fsm_q == EXEC) && !Stall;
  assign IMEM_Req  = req_q;
  assign IMEM_Addr = pc_q;
  assign PC        = pc_q;
  assign IR        = ir_q;
  assign State     = state_q;
  assign InstCount = count_q;

endmodule

// File: tb/tb_cpu_fetch_sequencer.sv
// Scoreboard bench for cpu_fetch_sequencer: each step pushes the hand-derived
// post-edge register state, then pops and compares it after the clock edge.
module tb_cpu_fetch_sequencer;

  logic        CLK = 1'b0;
  logic        RST_n;
  logic [1:0]  PS;
  logic        IR_L;
  logic        NS;
  logic [15:0] RA_Data;
  logic [15:0] Offset;
  logic        Stall;
  logic        IMEM_Valid;
  logic [15:0] IMEM_Data;
  logic        IMEM_Req;
  logic [15:0] IMEM_Addr;
  logic [15:0] IR;
  logic        State;
  logic [15:0] PC;
  logic        Exec;
  logic [15:0] InstCount;

  int check_count = 0;
  int pass_count  = 0;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] ir;
    logic        state;
    logic        req;
    logic [15:0] count;
  } exp_t;

  exp_t exp_q[$];

  cpu_fetch_sequencer #(.PC_W(16), .RESET_VECTOR(16'h0000)) dut (
    .CLK        (CLK),
    .RST_n      (RST_n),
    .PS         (PS),
    .IR_L       (IR_L),
    .NS         (NS),
    .RA_Data    (RA_Data),
    .Offset     (Offset),
    .Stall      (Stall),
    .IMEM_Valid (IMEM_Valid),
    .IMEM_Data  (IMEM_Data),
    .IMEM_Req   (IMEM_Req),
    .IMEM_Addr  (IMEM_Addr),
    .IR         (IR),
    .State      (State),
    .PC         (PC),
    .Exec       (Exec),
    .InstCount  (InstCount)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
  endtask

  // One clock step: drive inputs, check combinational Exec, then compare the
  // registered state after the edge against the queued expectation.
  task automatic applyStimulus(
    input string       tag,
    input logic        rst_n,
    input logic [1:0]  ps,
    input logic        ir_l,
    input logic        ns,
    input logic [15:0] ra,
    input logic [15:0] off,
    input logic        stall,
    input logic        valid,
    input logic [15:0] data,
    input logic        exp_exec,
    input logic [15:0] exp_pc,
    input logic [15:0] exp_ir,
    input logic        exp_state,
    input logic        exp_req,
    input logic [15:0] exp_count);
    exp_t e;
    RST_n = rst_n; PS = ps; IR_L = ir_l; NS = ns; RA_Data = ra; Offset = off;
    Stall = stall; IMEM_Valid = valid; IMEM_Data = data;
    #1;
    checkOutput({tag, ".exec"}, {31'd0, Exec}, {31'd0, exp_exec});
    exp_q.push_back('{pc: exp_pc, ir: exp_ir, state: exp_state, req: exp_req,
                      count: exp_count});
    @(posedge CLK);
    #1;
    e = exp_q.pop_front();
    checkOutput({tag, ".pc"},    {16'd0, PC},        {16'd0, e.pc});
    checkOutput({tag, ".addr"},  {16'd0, IMEM_Addr}, {16'd0, e.pc});
    checkOutput({tag, ".ir"},    {16'd0, IR},        {16'd0, e.ir});
    checkOutput({tag, ".state"}, {31'd0, State},     {31'd0, e.state});
    checkOutput({tag, ".req"},   {31'd0, IMEM_Req},  {31'd0, e.req});
    checkOutput({tag, ".count"}, {16'd0, InstCount}, {16'd0, e.count});
  endtask

  initial begin
    RST_n = 1'b0; PS = 2'b00; IR_L = 1'b0; NS = 1'b0; RA_Data = '0; Offset = '0;
    Stall = 1'b0; IMEM_Valid = 1'b0; IMEM_Data = '0;
    repeat (2) @(posedge CLK);
    #1;

    //            tag      rst ps    irl ns ra       off      stl vld data      exec pc       ir       st req cnt
    applyStimulus("rst",   0, 2'b00, 0, 0, 16'h0,   16'h0,   0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 16'd0);
    // Scenario 1: three wait cycles then A005
    applyStimulus("t1req", 1, 2'b00, 0, 0, 16'h0,   16'h0,   0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 1, 16'd0);
    applyStimulus("t1w1",  1, 2'b00, 0, 0, 16'h0,   16'h0,   0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 1, 16'd0);
    applyStimulus("t1w2",  1, 2'b00, 0, 0, 16'h0,   16'h0,   0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 1, 16'd0);
    applyStimulus("t1w3",  1, 2'b01, 1, 1, 16'h0,   16'h0,   0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 1, 16'd0);
    applyStimulus("t1acc", 1, 2'b00, 0, 0, 16'h0,   16'h0,   0, 1, 16'hA005, 0, 16'h0000, 16'hA005, 0, 0, 16'd0);
    // Scenario 2: PC+1 and retire
    applyStimulus("t2ex",  1, 2'b01, 1, 0, 16'h0,   16'h0,   0, 0, 16'h0000, 1, 16'h0001, 16'hA005, 0, 0, 16'd1);
    // Scenario 3: EX0 -> EX1 -> retire once
    applyStimulus("t3req", 1, 2'b00, 0, 0, 16'h0,   16'h0,   0, 0, 16'h0000, 0, 16'h0001, 16'hA005, 0, 1, 16'd1);
    applyStimulus("t3acc", 1, 2'b00, 0, 0, 16'h0,   16'h0,   0, 1, 16'h1111, 0, 16'h0001, 16'h1111, 0, 0, 16'd1);
    applyStimulus("t3ex0", 1, 2'b00, 1, 1, 16'h0,   16'h0,   0, 0, 16'h0000, 1, 16'h0001, 16'h1111, 1, 0, 16'd1);
    applyStimulus("t3ex1", 1, 2'b00, 1, 0, 16'h0,   16'h0,   0, 0, 16'h0000, 1, 16'h0001, 16'h1111, 0, 0, 16'd2);
    // Scenario 4: offset wrap then register jump, multi-cycle EX0, IMEM ignored in EXEC
    applyStimulus("t4req", 1, 2'b00, 0, 0, 16'h0,   16'h0,   0, 0, 16'h0000, 0, 16'h0001, 16'h1111, 0, 1, 16'd2);
    applyStimulus("t4acc", 1, 2'b00, 0, 0, 16'h0,   16'h0,   0, 1, 16'h2222, 0, 16'h0001, 16'h2222, 0, 0, 16'd2);
    applyStimulus("t4off", 1, 2'b11, 0, 0, 16'h0,   16'hFFFE, 0, 0, 16'h0000, 1, 16'hFFFF, 16'h2222, 0, 0, 16'd2);
    applyStimulus("t4jmp", 1, 2'b10, 0, 0, 16'h1234, 16'h0,  0, 1, 16'hDEAD, 1, 16'h1234, 16'h2222, 0, 0, 16'd2);
    // Scenario 5: four stalled cycles freeze everything
    for (int i = 0; i < 4; i++)
      applyStimulus("t5stl", 1, 2'b01, 1, 1, 16'h0, 16'h0,   1, 0, 16'h0000, 0, 16'h1234, 16'h2222, 0, 0, 16'd2);
    applyStimulus("t5go",  1, 2'b01, 0, 0, 16'h0,   16'h0,   0, 0, 16'h0000, 1, 16'h1235, 16'h2222, 0, 0, 16'd2);
    applyStimulus("t5ret", 1, 2'b01, 1, 0, 16'h0,   16'h0,   0, 0, 16'h0000, 1, 16'h1236, 16'h2222, 0, 0, 16'd3);
    // Valid without request and decoder inputs are ignored in FETCH
    applyStimulus("t5ign", 1, 2'b01, 1, 1, 16'h0,   16'h0,   0, 1, 16'h5555, 0, 16'h1236, 16'h2222, 0, 1, 16'd3);
    // Scenario 6: reset while a request is pending
    applyStimulus("t6rs0", 0, 2'b00, 0, 0, 16'h0,   16'h0,   0, 1, 16'hBEEF, 0, 16'h0000, 16'h0000, 0, 0, 16'd0);
    applyStimulus("t6rs1", 0, 2'b00, 0, 0, 16'h0,   16'h0,   0, 1, 16'hBEEF, 0, 16'h0000, 16'h0000, 0, 0, 16'd0);
    applyStimulus("t6rel", 1, 2'b00, 0, 0, 16'h0,   16'h0,   0, 1, 16'hBEEF, 0, 16'h0000, 16'h0000, 0, 1, 16'd0);
    applyStimulus("t6acc", 1, 2'b00, 0, 0, 16'h0,   16'h0,   0, 1, 16'h7777, 0, 16'h0000, 16'h7777, 0, 0, 16'd0);
    applyStimulus("t6ex",  1, 2'b00, 0, 0, 16'h0,   16'h0,   0, 0, 16'h0000, 1, 16'h0000, 16'h7777, 0, 0, 16'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
